// File: rtl/pixel_window_buffer.sv
// ---------------------------------------------------------------------------
// pixel_window_buffer
//   Turns a raster-order pixel stream into 3x3 neighbourhoods for the
//   edge-detect stage. Two row line buffers (lineA = previous row,
//   lineB = the row before that) feed a 3x3 shift window. One window is
//   emitted per interior pixel and tagged with the centre pixel's X/Y.
//
//   Latency from the accepted pixel to its window strobe is fixed at 2 cycles.
//   The pipeline sustains one window per cycle.
//
// Ports
//   mainClk        in   system clock, rising edge
//   nreset         in   asynchronous active-low reset
//   frameStart     in   1-cycle pulse; the next accepted pixel is (0,0)
//   pixelIn        in   pixel value, raster order
//   pixelInValid   in   pixelIn is valid this cycle
//   pixelData      out  window [r][c]; r=0 is row y-1, c=0 is column x-1
//   pixelDataValid out  1-cycle strobe qualifying pixelData/spiXVal/spiYVal
//   spiXVal        out  centre column
//   spiYVal        out  centre row
//   frameDone      out  1-cycle pulse, registered on acceptance of the last pixel
//   overrun        out  sticky; a pixel arrived after frameDone and before frameStart
// ---------------------------------------------------------------------------
module pixel_window_buffer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = 4
) (
  input  logic                         mainClk,
  input  logic                         nreset,
  input  logic                         frameStart,
  input  logic [PIX_W-1:0]             pixelIn,
  input  logic                         pixelInValid,
  output logic [2:0][2:0][PIX_W-1:0]   pixelData,
  output logic                         pixelDataValid,
  output logic [9:0]                   spiXVal,
  output logic [8:0]                   spiYVal,
  output logic                         frameDone,
  output logic                         overrun
);

  localparam int         LP_AW     = $clog2(IMG_WIDTH);
  localparam logic [9:0] LP_X_LAST = 10'(IMG_WIDTH - 1);
  localparam logic [8:0] LP_Y_LAST = 9'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t               r_state;
  logic [9:0]           r_col;
  logic [8:0]           r_row;

  // Line buffers and their registered read data
  logic [PIX_W-1:0]     r_line_a [0:IMG_WIDTH-1];
  logic [PIX_W-1:0]     r_line_b [0:IMG_WIDTH-1];
  logic [PIX_W-1:0]     r_rd_a;
  logic [PIX_W-1:0]     r_rd_b;

  // Stage 1: accepted pixel and its coordinates, aligned with the RAM read data
  logic                 r_s1_valid;
  logic [PIX_W-1:0]     r_s1_pix;
  logic [9:0]           r_s1_x;
  logic [8:0]           r_s1_y;

  logic                 w_accept;
  logic [9:0]           w_x;
  logic [8:0]           w_y;
  logic                 w_last_col;
  logic                 w_last_pix;
  logic [2:0][PIX_W-1:0]         w_new_col;
  logic [2:0][2:0][PIX_W-1:0]    w_win_next;

  // A frameStart pulse both restarts the counters and lets a coincident
  // pixel be taken as (0,0), whatever state we were in.
  assign w_accept   = pixelInValid && (frameStart || (r_state == ACTIVE));
  assign w_x        = frameStart ? '0 : r_col;
  assign w_y        = frameStart ? '0 : r_row;
  assign w_last_col = (w_x == LP_X_LAST);
  assign w_last_pix = w_last_col && (w_y == LP_Y_LAST);

  // Control FSM, counters and status outputs
  always_ff @(posedge mainClk or negedge nreset) begin
    if (!nreset) begin
      r_state   <= IDLE;
      r_col     <= '0;
      r_row     <= '0;
      frameDone <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frameDone <= 1'b0;
      if (frameStart) begin
        r_state <= ACTIVE;
        r_col   <= '0;
        r_row   <= '0;
      end
      if (w_accept) begin
        if (w_last_pix) begin
          r_state   <= DONE;
          frameDone <= 1'b1;
          r_col     <= '0;
          r_row     <= '0;
        end else if (w_last_col) begin
          r_col <= '0;
          r_row <= w_y + 9'd1;
        end else begin
          r_col <= w_x + 10'd1;
        end
      end
      if (pixelInValid && !frameStart && (r_state == DONE))
        overrun <= 1'b1;
    end
  end

  // Line buffers: read-before-write on lineA at the current column. lineB
  // receives the old lineA word one cycle later from the registered read;
  // the next access to that column is a full row away, so no hazard.
  always_ff @(posedge mainClk) begin
    if (w_accept) begin
      r_rd_a                  <= r_line_a[w_x[LP_AW-1:0]];
      r_rd_b                  <= r_line_b[w_x[LP_AW-1:0]];
      r_line_a[w_x[LP_AW-1:0]] <= pixelIn;
    end
    if (r_s1_valid)
      r_line_b[r_s1_x[LP_AW-1:0]] <= r_rd_a;
  end

  always_ff @(posedge mainClk or negedge nreset) begin
    if (!nreset) begin
      r_s1_valid <= 1'b0;
      r_s1_pix   <= '0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_pix <= pixelIn;
        r_s1_x   <= w_x;
        r_s1_y   <= w_y;
      end
    end
  end

  // New right-hand column: oldest row at r=0, current pixel at r=2
  assign w_new_col = {r_s1_pix, r_rd_a, r_rd_b};

  // Each window row shifts left by one column and takes the new pixel in c=2
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_row
      assign w_win_next[gi] = {w_new_col[gi], pixelData[gi][2:1]};
    end
  endgenerate

  // Stage 2: window and strobe. The window is not flushed at row wrap;
  // the x>=2 / y>=2 gate hides any window straddling two rows or frames.
  always_ff @(posedge mainClk or negedge nreset) begin
    if (!nreset) begin
      pixelData      <= '0;
      pixelDataValid <= 1'b0;
      spiXVal        <= '0;
      spiYVal        <= '0;
    end else begin
      pixelDataValid <= 1'b0;
      if (r_s1_valid) begin
        pixelData <= w_win_next;
        if ((r_s1_x >= 10'd2) && (r_s1_y >= 9'd2)) begin
          pixelDataValid <= 1'b1;
          spiXVal        <= r_s1_x - 10'd1;
          spiYVal        <= r_s1_y - 9'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_window_buffer.sv
// ---------------------------------------------------------------------------
// tb_pixel_window_buffer
//   Directed bench for pixel_window_buffer on an 8x6 image. Pixel value at
//   (x,y) is (x+y)&15, so every expected window follows from its centre
//   coordinates. Each stepped cycle checks the strobe (expected exactly two
//   cycles after an interior pixel), coordinates, window contents and
//   frameDone.
// ---------------------------------------------------------------------------
module tb_pixel_window_buffer;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int PW = 4;

  logic                     mainClk = 1'b0;
  logic                     nreset = 1'b0;
  logic                     frameStart = 1'b0;
  logic [PW-1:0]            pixelIn = '0;
  logic                     pixelInValid = 1'b0;
  logic [2:0][2:0][PW-1:0]  pixelData;
  logic                     pixelDataValid;
  logic [9:0]               spiXVal;
  logic [8:0]               spiYVal;
  logic                     frameDone;
  logic                     overrun;

  pixel_window_buffer #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .PIX_W     (PW)
  ) dut (
    .mainClk       (mainClk),
    .nreset        (nreset),
    .frameStart    (frameStart),
    .pixelIn       (pixelIn),
    .pixelInValid  (pixelInValid),
    .pixelData     (pixelData),
    .pixelDataValid(pixelDataValid),
    .spiXVal       (spiXVal),
    .spiYVal       (spiYVal),
    .frameDone     (frameDone),
    .overrun       (overrun)
  );

  always #5 mainClk = ~mainClk;

  typedef struct {
    int due;
    int x;
    int y;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   strobes  = 0;
  int   s0       = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Window centred on (x,y) with pixel value (px+py)&15
  function automatic logic [63:0] win_exp(input int x, input int y);
    logic [2:0][2:0][PW-1:0] w;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[r][c] = 4'((x - 1 + c + y - 1 + r) & 15);
    return 64'(w);
  endfunction

  // One clock: drive inputs, sample 1 time unit after the edge, check outputs
  task automatic step(input bit fs, input bit v, input logic [PW-1:0] p, input bit fd);
    exp_t e;
    frameStart   = fs;
    pixelInValid = v;
    pixelIn      = p;
    @(posedge mainClk);
    #1;
    cyc++;
    chk("frameDone", 64'(frameDone), 64'(fd));
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      strobes++;
      chk("strobe", 64'(pixelDataValid), 64'd1);
      chk("spiX", 64'(spiXVal), 64'(e.x));
      chk("spiY", 64'(spiYVal), 64'(e.y));
      chk("window", 64'(pixelData), win_exp(e.x, e.y));
    end else begin
      chk("no_strobe", 64'(pixelDataValid), 64'd0);
    end
  endtask

  // First npix pixels of a frame; gap idle cycles after each pixel
  task automatic drive_frame(input int gap, input int npix);
    int c0;
    int x;
    int y;
    for (int n = 0; n < npix; n++) begin
      x  = n % W;
      y  = n / W;
      c0 = cyc;
      step(n == 0, 1'b1, 4'((x + y) & 15), n == W * H - 1);
      if (x >= 2 && y >= 2)
        q.push_back('{c0 + 2, x - 1, y - 1});
      repeat (gap) step(1'b0, 1'b0, 4'd0, 1'b0);
    end
  endtask

  task automatic flush_and_count(input string tag, input int want);
    repeat (3) step(1'b0, 1'b0, 4'd0, 1'b0);
    chk({tag, "_pending"}, 64'(q.size()), 64'd0);
    chk({tag, "_strobes"}, 64'(strobes - s0), 64'(want));
  endtask

  initial begin
    // Reset state
    repeat (3) step(1'b0, 1'b0, 4'd0, 1'b0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_spiX", 64'(spiXVal), 64'd0);
    chk("rst_spiY", 64'(spiYVal), 64'd0);
    chk("rst_window", 64'(pixelData), 64'd0);
    nreset = 1'b1;

    // IDLE drops pixels silently
    step(1'b0, 1'b1, 4'd9, 1'b0);
    step(1'b0, 1'b1, 4'd3, 1'b0);
    chk("idle_overrun", 64'(overrun), 64'd0);

    // 1: back-to-back frame; strobes at x=0,1 of each row are excluded
    s0 = strobes;
    drive_frame(0, W * H);
    flush_and_count("f1", (W - 2) * (H - 2));
    chk("f1_overrun", 64'(overrun), 64'd0);

    // 2: valid toggling 1/0; same windows, each 2 cycles after its pixel
    s0 = strobes;
    drive_frame(1, W * H);
    flush_and_count("f2", (W - 2) * (H - 2));

    // 4: extra pixels after frameDone -> no strobes, overrun sticky
    for (int k = 0; k < 10; k++)
      step(1'b0, 1'b1, 4'(k), 1'b0);
    chk("ovr_set", 64'(overrun), 64'd1);
    s0 = strobes;
    drive_frame(0, W * H);
    flush_and_count("f4", (W - 2) * (H - 2));
    chk("ovr_sticky", 64'(overrun), 64'd1);

    // 5: reset mid-frame at pixel 30, then a clean frame
    drive_frame(0, 30);
    nreset = 1'b0;
    #1;
    q.delete();
    chk("mid_rst_valid", 64'(pixelDataValid), 64'd0);
    chk("mid_rst_window", 64'(pixelData), 64'd0);
    chk("mid_rst_overrun", 64'(overrun), 64'd0);
    chk("mid_rst_spiX", 64'(spiXVal), 64'd0);
    for (int k = 0; k < 3; k++)
      step(1'b0, 1'b1, 4'(k + 5), 1'b0);
    nreset = 1'b1;
    s0 = strobes;
    drive_frame(0, W * H);
    flush_and_count("f5", (W - 2) * (H - 2));
    chk("f5_overrun", 64'(overrun), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
